// File: rtl/pop_arbiter_rr.sv
// Round-robin pop arbiter: drains four source FIFOs into one downstream FIFO
// with a fixed two-cycle pop-to-push latency and a sticky error state.
module pop_arbiter_rr #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    fifo_empty,
  input  logic [3:0]    fifo_error,
  input  logic [3:0]    fifo_valid,
  input  logic [4*DW-1:0] fifo_data,
  input  logic          down_almost_full,
  input  logic          down_error,
  output logic [3:0]    pop,
  output logic          push_out,
  output logic [DW-1:0] data_out,
  output logic [1:0]    src_id,
  output logic          idle,
  output logic          error_out
);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_IDLE   = 5'b00010,
    S_ACTIVE = 5'b00100,
    S_PAUSE  = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t r_state;
  logic [1:0] r_last;
  logic [1:0] r_pend_idx;
  logic       r_pend_vld;
  logic       r_pop_d2;

  logic [1:0]    w_c;
  logic [1:0]    w_gnt_idx;
  logic          w_gnt_vld;
  logic          w_pop_en;
  logic [3:0]    w_pend_oh;
  logic [3:0]    w_unexp;
  logic          w_err;
  logic          w_push;
  logic          w_any;
  logic [DW-1:0] w_slice;

  // Lowest offset from last grant wins; offset 4 is the last grant itself.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 2'd0;
    w_c       = r_last;
    for (int k = 4; k >= 1; k--) begin
      w_c = r_last + 2'(k);
      if (!fifo_empty[w_c]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_c;
      end
    end
  end

  assign w_any    = ~&fifo_empty;
  assign w_pop_en = (r_state == S_ACTIVE) && !down_almost_full && w_gnt_vld;
  assign pop      = w_pop_en ? (4'b0001 << w_gnt_idx) : 4'b0000;

  assign w_pend_oh = r_pend_vld ? (4'b0001 << r_pend_idx) : 4'b0000;
  assign w_unexp   = fifo_valid & ~w_pend_oh;
  assign w_err     = (r_state != S_RESET) &&
                     (|fifo_error || down_error || |w_unexp);
  assign w_push    = r_pend_vld && fifo_valid[r_pend_idx];
  assign w_slice   = fifo_data[DW*r_pend_idx +: DW];

  assign idle = (r_state == S_IDLE) && !r_pend_vld && !r_pop_d2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RESET;
      r_last     <= 2'd3;
      r_pend_idx <= 2'd0;
      r_pend_vld <= 1'b0;
      r_pop_d2   <= 1'b0;
      push_out   <= 1'b0;
      data_out   <= '0;
      src_id     <= 2'd0;
      error_out  <= 1'b0;
    end else if (w_err || r_state == S_ERROR) begin
      r_state    <= S_ERROR;
      r_pend_vld <= 1'b0;
      r_pop_d2   <= 1'b0;
      push_out   <= 1'b0;
      error_out  <= 1'b1;
    end else begin
      r_pend_vld <= w_pop_en;
      r_pop_d2   <= r_pend_vld;
      push_out   <= w_push;
      if (w_pop_en) begin
        r_pend_idx <= w_gnt_idx;
        r_last     <= w_gnt_idx;
      end
      if (w_push) begin
        data_out <= w_slice;
        src_id   <= r_pend_idx;
      end
      unique case (r_state)
        S_RESET: r_state <= S_IDLE;
        S_IDLE: begin
          if (down_almost_full) r_state <= S_PAUSE;
          else if (w_any)       r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (down_almost_full) r_state <= S_PAUSE;
          else if (!w_any)      r_state <= S_IDLE;
        end
        S_PAUSE: begin
          if (!down_almost_full)
            r_state <= w_any ? S_ACTIVE : S_IDLE;
        end
        default: r_state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_pop_arbiter_rr.sv
// Directed bench for pop_arbiter_rr: grant order, latency, pause,
// error handling and reset behaviour.
module tb_pop_arbiter_rr;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    fifo_empty;
  logic [3:0]    fifo_error;
  logic [3:0]    fifo_valid;
  logic [4*DW-1:0] fifo_data;
  logic          down_almost_full;
  logic          down_error;
  logic [3:0]    pop;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic [1:0]    src_id;
  logic          idle;
  logic          error_out;

  logic [3:0] vld_q = 4'b0;
  logic [3:0] inj_valid = 4'b0;
  logic       auto_en = 1'b1;
  logic [7:0] exp_data [4];

  int total = 0;
  int bad = 0;

  pop_arbiter_rr #(.DW(DW)) dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_error(fifo_error),
    .fifo_valid(fifo_valid),
    .fifo_data(fifo_data),
    .down_almost_full(down_almost_full),
    .down_error(down_error),
    .pop(pop),
    .push_out(push_out),
    .data_out(data_out),
    .src_id(src_id),
    .idle(idle),
    .error_out(error_out)
  );

  always #5 clk = ~clk;

  // Source FIFO model: data_out valid one cycle after a pop.
  always @(posedge clk) vld_q <= pop;
  assign fifo_valid = (auto_en ? vld_q : 4'b0) | inj_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    fifo_empty = 4'b1111;
    fifo_error = 4'b0;
    down_almost_full = 1'b0;
    down_error = 1'b0;
    inj_valid  = 4'b0;
    auto_en    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    exp_data[0] = 8'hA0;
    exp_data[1] = 8'hB1;
    exp_data[2] = 8'hC2;
    exp_data[3] = 8'hD3;
    fifo_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    reset      = 1'b1;
    fifo_empty = 4'b1111;
    fifo_error = 4'b0;
    down_almost_full = 1'b0;
    down_error = 1'b0;
    tick();
    tick();
    chk("rst_pop", 32'(pop), 0);
    chk("rst_push", 32'(push_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_src", 32'(src_id), 0);
    chk("rst_idle", 32'(idle), 0);
    chk("rst_err", 32'(error_out), 0);
    reset = 1'b0;
    tick();
    chk("idle_after_rst", 32'(idle), 1);

    // Sources 0 and 2 alternate
    fifo_empty = 4'b1010;
    #1;
    chk("a_idle_pop", 32'(pop), 0);
    tick();
    #1;
    chk("a_pop1", 32'(pop), 4'b0001);
    tick();
    #1;
    chk("a_pop2", 32'(pop), 4'b0100);
    chk("a_nopush", 32'(push_out), 0);
    tick();
    #1;
    chk("a_pop3", 32'(pop), 4'b0001);
    chk("a_push1", 32'(push_out), 1);
    chk("a_src1", 32'(src_id), 0);
    chk("a_data1", 32'(data_out), 8'hA0);
    tick();
    #1;
    chk("a_pop4", 32'(pop), 4'b0100);
    chk("a_push2", 32'(push_out), 1);
    chk("a_src2", 32'(src_id), 2);
    chk("a_data2", 32'(data_out), 8'hC2);
    tick();
    fifo_empty = 4'b1111;
    #1;
    chk("a_pop5", 32'(pop), 0);
    chk("a_src3", 32'(src_id), 0);
    tick();
    #1;
    chk("a_src4", 32'(src_id), 2);
    chk("a_idle_busy", 32'(idle), 0);
    tick();
    #1;
    chk("a_push_end", 32'(push_out), 0);
    chk("a_data_hold", 32'(data_out), 8'hC2);
    chk("a_idle_end", 32'(idle), 1);

    // All four sources, back-to-back
    do_reset();
    fifo_empty = 4'b0000;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k == 8) fifo_empty = 4'b1111;
      #1;
      if (k < 8) chk("b_pop", 32'(pop), 32'(4'b0001 << (k % 4)));
      else       chk("b_pop_off", 32'(pop), 0);
      if (k >= 2) begin
        chk("b_push", 32'(push_out), 1);
        chk("b_src", 32'(src_id), 32'((k - 2) % 4));
        chk("b_data", 32'(data_out), 32'(exp_data[(k - 2) % 4]));
      end
      tick();
    end
    chk("b_push_end", 32'(push_out), 0);

    // Pause after grant to source 1
    do_reset();
    fifo_empty = 4'b0000;
    tick();
    #1;
    chk("c_pop0", 32'(pop), 4'b0001);
    tick();
    #1;
    chk("c_pop1", 32'(pop), 4'b0010);
    tick();
    down_almost_full = 1'b1;
    #1;
    chk("c_pop_paused", 32'(pop), 0);
    chk("c_push0", 32'(src_id), 0);
    tick();
    #1;
    chk("c_pop_p2", 32'(pop), 0);
    chk("c_push1", 32'(push_out), 1);
    chk("c_src1", 32'(src_id), 1);
    chk("c_data1", 32'(data_out), 8'hB1);
    tick();
    #1;
    chk("c_push_none", 32'(push_out), 0);
    tick();
    down_almost_full = 1'b0;
    #1;
    chk("c_pop_p3", 32'(pop), 0);
    tick();
    #1;
    chk("c_resume", 32'(pop), 4'b0100);
    tick();
    fifo_empty = 4'b1111;
    tick();
    #1;
    chk("c_src2", 32'(src_id), 2);
    chk("c_data2", 32'(data_out), 8'hC2);

    // Source error while active
    do_reset();
    fifo_empty = 4'b0000;
    tick();
    tick();
    fifo_error = 4'b1000;
    tick();
    fifo_error = 4'b0000;
    #1;
    chk("d_err", 32'(error_out), 1);
    chk("d_pop", 32'(pop), 0);
    chk("d_push", 32'(push_out), 0);
    tick();
    tick();
    #1;
    chk("d_err_sticky", 32'(error_out), 1);
    chk("d_pop_sticky", 32'(pop), 0);
    chk("d_idle", 32'(idle), 0);
    reset = 1'b1;
    tick();
    chk("d_rst_err", 32'(error_out), 0);
    reset = 1'b0;
    fifo_empty = 4'b1111;
    tick();
    chk("d_rst_idle", 32'(idle), 1);

    // Unexpected valid
    do_reset();
    fifo_empty = 4'b1110;
    tick();
    #1;
    chk("e_pop", 32'(pop), 4'b0001);
    tick();
    inj_valid = 4'b0100;
    #1;
    chk("e_err_pre", 32'(error_out), 0);
    tick();
    inj_valid = 4'b0000;
    chk("e_err", 32'(error_out), 1);

    // Underflow: pending pop with no valid
    do_reset();
    auto_en = 1'b0;
    fifo_empty = 4'b1110;
    tick();
    #1;
    chk("e2_pop", 32'(pop), 4'b0001);
    tick();
    fifo_empty = 4'b1111;
    tick();
    chk("e2_push", 32'(push_out), 0);
    chk("e2_err", 32'(error_out), 0);
    tick();
    chk("e2_push2", 32'(push_out), 0);
    chk("e2_err2", 32'(error_out), 0);
    auto_en = 1'b1;

    // Reset one cycle after a pop
    do_reset();
    fifo_empty = 4'b0000;
    tick();
    #1;
    chk("f_pop", 32'(pop), 4'b0001);
    tick();
    reset = 1'b1;
    tick();
    chk("f_push", 32'(push_out), 0);
    chk("f_data", 32'(data_out), 0);
    chk("f_src", 32'(src_id), 0);
    chk("f_pop_rst", 32'(pop), 0);
    chk("f_idle", 32'(idle), 0);
    chk("f_err", 32'(error_out), 0);
    reset = 1'b0;
    tick();
    chk("f_push2", 32'(push_out), 0);
    chk("f_pop_idle", 32'(pop), 0);
    tick();
    #1;
    chk("f_first_gnt", 32'(pop), 4'b0001);
    fifo_empty = 4'b1111;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pop_arbiter_rr.md
POP_ARBITER_RR -- requirements
Module: pop_arbiter_rr

Interface
REQ-001 Parameter DW, default 8: data width of each source FIFO and of the output.
REQ-002 Parameter N is fixed at 4 sources; it is not a parameter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fifo_empty  input  4  bit i = source FIFO i empty.
REQ-006 fifo_error  input  4  bit i = source FIFO i error.
REQ-007 fifo_valid  input  4  bit i = source FIFO i data_out valid.
REQ-008 fifo_data  input  4*DW  source i data in bits [i*DW+DW-1 : i*DW].
REQ-009 down_almost_full  input  1  downstream FIFO almost-full (pause request).
REQ-010 down_error  input  1  downstream FIFO error.
REQ-011 pop  output  4  one-hot (or zero) pop request to source FIFOs.
REQ-012 push_out  output  1  registered push to downstream FIFO.
REQ-013 data_out  output  DW  registered data accompanying push_out.
REQ-014 src_id  output  2  registered index of the source of data_out.
REQ-015 idle  output  1  all sources empty and nothing in flight.
REQ-016 error_out  output  1  sticky error flag.

Function
REQ-017 States SHALL be RESET, IDLE, ACTIVE, PAUSE, ERROR, one-hot encoded.
REQ-018 RESET -> IDLE on the first cycle with reset=0.
REQ-019 IDLE -> ACTIVE when fifo_empty != 4'b1111; ACTIVE -> IDLE when fifo_empty == 4'b1111.
REQ-020 ACTIVE or IDLE -> PAUSE when down_almost_full=1; PAUSE -> ACTIVE when down_almost_full=0 and any source is non-empty, else PAUSE -> IDLE.
REQ-021 Any state except RESET -> ERROR when fifo_error != 0, down_error=1, or an unexpected valid occurs (REQ-027); ERROR has priority over all other transitions.
REQ-022 ERROR SHALL persist until reset; in ERROR pop=0, push_out=0, error_out=1.
REQ-023 pop SHALL be combinational and nonzero only in ACTIVE with down_almost_full=0.
REQ-024 Grant: the first i with fifo_empty[i]=0, searching from (last_grant+1) mod 4 upward with wrap from 3 to 0; last_grant updates to i on each cycle pop[i]=1.
REQ-025 At most one pop per cycle; a source that stays non-empty is re-granted only after the other non-empty sources have each been granted once.
REQ-026 Pipeline: pop[i] in cycle n -> fifo_valid[i] expected in n+1 -> push_out=1, data_out=fifo_data[i], src_id=i in n+2; fixed latency 2 cycles.
REQ-027 A pending register SHALL record the granted index per cycle; fifo_valid asserted on any bit other than the pending index is an unexpected valid.
REQ-028 Pending pop with no fifo_valid in n+1 (source underflow) SHALL produce no push and no error.
REQ-029 In-flight items SHALL complete their push when entering PAUSE; no new pops while paused.
REQ-030 Back-to-back throughput: one push per cycle when sources are non-empty and down_almost_full=0.
REQ-031 idle=1 only in IDLE with no pops in the previous two cycles.
REQ-032 data_out SHALL hold its last value when push_out=0.

Reset
REQ-033 reset=1 at a clock edge SHALL force state=RESET, last_grant=3 (first grant favors source 0), pending cleared, push_out=0, data_out=0, src_id=0, error_out=0; pop=0 and idle=0 while in RESET.
REQ-034 Reset mid-transfer SHALL discard in-flight items with no push.
REQ-035 Reset SHALL be the only exit from ERROR.

Verification
REQ-036 Sources 0 and 2 non-empty, others empty, down_almost_full=0 -> pop sequence 0001,0100,0001,0100; push_out with src_id 0,2,0,2 two cycles after each pop.
REQ-037 All four sources non-empty for 8 cycles -> grants 0,1,2,3,0,1,2,3; 8 consecutive pushes with data_out equal to fifo_data slices.
REQ-038 down_almost_full=1 raised after pop to source 1 -> pop=0 next cycle, source-1 item still pushed; drop down_almost_full -> grant resumes at source 2.
REQ-039 fifo_error[3]=1 for one cycle during ACTIVE -> ERROR next cycle, error_out=1, pop=0 until reset; reset -> IDLE, error_out=0.
REQ-040 fifo_valid[2]=1 while pending index is 0 -> ERROR; separately, pending pop with no valid -> no push, no error.
REQ-041 reset asserted one cycle after a pop -> no push_out, all outputs at reset values, first grant after reset to source 0.
